// File: rtl/mcpu_ctrl_ext.sv
// rtl/mcpu_ctrl_ext.sv - multi-cycle MIPS-style CPU control FSM
// Define MCPU_EXC_EN to build illegal-instruction, overflow and memory-wait watchdog exceptions.
module mcpu_ctrl_ext #(
  parameter int unsigned      TMO_W   = 8,
  parameter logic [TMO_W-1:0] TMO_MAX = 8'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic [31:0] inst_in,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        mem_w,
  output logic        CPU_MIO,
  output logic        IRWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrc_A,
  output logic [1:0]  ALUSrc_B,
  output logic [1:0]  DatatoReg,
  output logic [1:0]  RegDst,
  output logic [3:0]  ALU_Control,
  output logic [4:0]  state_out,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic [1:0]  cause
);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_EX_R = 5'd2, S_EX_MEM = 5'd3, S_EX_I = 5'd4,
    S_EX_BEQ = 5'd5, S_EX_BNE = 5'd6, S_EX_J = 5'd7, S_EX_JAL = 5'd8,
    S_EX_JR = 5'd9, S_EX_JALR = 5'd10, S_MEM_RD = 5'd11, S_MEM_WD = 5'd12,
    S_WB_R = 5'd13, S_WB_I = 5'd14, S_WB_LW = 5'd15, S_WB_LUI = 5'd16,
    S_EXC = 5'd17, S_ERROR = 5'd31
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011, ALU_SADD = 4'b0100, ALU_SSUB = 4'b0101;
  localparam logic [3:0] ALU_UADD = 4'b0110, ALU_USUB = 4'b0111, ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001, ALU_SRA  = 4'b1010, ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

`ifdef MCPU_EXC_EN
  localparam state_t S_ILL = S_EXC;
`else
  localparam state_t S_ILL = S_ERROR;
`endif

  state_t     state_q, state_d, id_next;
  logic [3:0] alu_op;
  logic       is_shift, ov_op;
  logic [5:0] op, fn;
  logic       unused_bits;

  assign op = inst_in[31:26];
  assign fn = inst_in[5:0];
  assign state_out = state_q;
  assign unused_bits = ^{inst_in[25:6], overflow, ov_op, TMO_MAX};

  // The IR is stable from ID to writeback, so decode is shared by every state.
  always_comb begin
    id_next  = S_ILL;
    alu_op   = ALU_SADD;
    is_shift = 1'b0;
    ov_op    = 1'b0;
    case (op)
      6'h00: begin
        id_next = S_EX_R;
        case (fn)
          6'h20: begin alu_op = ALU_SADD; ov_op = 1'b1; end
          6'h21: alu_op = ALU_UADD;
          6'h22: begin alu_op = ALU_SSUB; ov_op = 1'b1; end
          6'h23: alu_op = ALU_USUB;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2A: alu_op = ALU_SLT;
          6'h2B: alu_op = ALU_SLTU;
          6'h00: begin alu_op = ALU_SLL; is_shift = 1'b1; end
          6'h02: begin alu_op = ALU_SRL; is_shift = 1'b1; end
          6'h03: begin alu_op = ALU_SRA; is_shift = 1'b1; end
          6'h08: id_next = S_EX_JR;
          6'h09: id_next = S_EX_JALR;
          default: id_next = S_ILL;
        endcase
      end
      6'h08: begin id_next = S_EX_I; alu_op = ALU_SADD; ov_op = 1'b1; end
      6'h09: begin id_next = S_EX_I; alu_op = ALU_UADD; end
      6'h0C: begin id_next = S_EX_I; alu_op = ALU_AND; end
      6'h0D: begin id_next = S_EX_I; alu_op = ALU_OR; end
      6'h0E: begin id_next = S_EX_I; alu_op = ALU_XOR; end
      6'h0A: begin id_next = S_EX_I; alu_op = ALU_SLT; end
      6'h0B: begin id_next = S_EX_I; alu_op = ALU_SLTU; end
      6'h0F: id_next = S_WB_LUI;
      6'h23, 6'h2B: id_next = S_EX_MEM;
      6'h04: id_next = S_EX_BEQ;
      6'h05: id_next = S_EX_BNE;
      6'h02: id_next = S_EX_J;
      6'h03: id_next = S_EX_JAL;
      default: id_next = S_ILL;
    endcase
  end

`ifdef MCPU_EXC_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic             stall;
  assign cause = cause_q;
`else
  assign cause = 2'b00;
`endif

  always_comb begin
    state_d     = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    mem_w       = 1'b0;
    CPU_MIO     = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    PCSource    = 2'b00;
    ALUSrc_A    = 2'b00;
    ALUSrc_B    = 2'b00;
    DatatoReg   = 2'b00;
    RegDst      = 2'b00;
    ALU_Control = 4'b0000;
    EPCWrite    = 1'b0;
    CauseWrite  = 1'b0;
    case (state_q)
      S_IF: begin
        CPU_MIO = 1'b1; ALUSrc_B = 2'b01; ALU_Control = ALU_SADD;
        IRWrite = MIO_ready; PCWrite = MIO_ready;
        state_d = MIO_ready ? S_ID : S_IF;
      end
      S_ID:     state_d = id_next;
      S_EX_R: begin
        ALU_Control = alu_op; ALUSrc_A = is_shift ? 2'b10 : 2'b01; state_d = S_WB_R;
      end
      S_EX_I:   begin ALU_Control = alu_op; ALUSrc_A = 2'b01; state_d = S_WB_I; end
      S_EX_MEM: begin
        ALU_Control = ALU_SADD; ALUSrc_A = 2'b01;
        state_d = (op == 6'h23) ? S_MEM_RD : S_MEM_WD;
      end
      S_EX_BEQ, S_EX_BNE: begin
        PCWriteCond = 1'b1; PCSource = 2'b01; ALU_Control = ALU_SSUB; ALUSrc_A = 2'b01;
        Branch = (state_q == S_EX_BEQ) ? zero : ~zero;
      end
      S_EX_J:   begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_EX_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1; DatatoReg = 2'b11; RegDst = 2'b10;
      end
      S_EX_JR:  begin PCWrite = 1'b1; PCSource = 2'b11; end
      S_EX_JALR: begin
        PCWrite = 1'b1; PCSource = 2'b11; RegWrite = 1'b1; DatatoReg = 2'b11; RegDst = 2'b01;
      end
      S_MEM_RD: begin CPU_MIO = 1'b1; IorD = 1'b1; state_d = MIO_ready ? S_WB_LW : S_MEM_RD; end
      S_MEM_WD: begin
        CPU_MIO = 1'b1; IorD = 1'b1; mem_w = MIO_ready; state_d = MIO_ready ? S_IF : S_MEM_WD;
      end
      S_WB_R:   begin RegWrite = 1'b1; RegDst = 2'b01; end
      S_WB_I:   RegWrite = 1'b1;
      S_WB_LW:  begin RegWrite = 1'b1; DatatoReg = 2'b01; end
      S_WB_LUI: begin RegWrite = 1'b1; DatatoReg = 2'b10; end
`ifdef MCPU_EXC_EN
      S_EXC: begin EPCWrite = 1'b1; CauseWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; end
`endif
      default: state_d = S_IF;
    endcase
`ifdef MCPU_EXC_EN
    cause_d = 2'b00;
    tmo_d   = '0;
    if (state_q == S_ID && id_next == S_ILL) cause_d = 2'b01;
    // Trap replaces the writeback state, so the overflowed result never lands.
    if (overflow && ov_op && (state_q == S_EX_R || state_q == S_EX_I)) begin
      state_d = S_EXC; cause_d = 2'b11;
    end
    stall = !MIO_ready && (state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_WD);
    if (stall) begin
      if (tmo_q == TMO_MAX - 1'b1) begin
        state_d = S_EXC; cause_d = 2'b10;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
`ifdef MCPU_EXC_EN
      tmo_q   <= '0;
      cause_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
`ifdef MCPU_EXC_EN
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl_ext.sv
// tb/tb_mcpu_ctrl_ext.sv - randomized and directed bench for mcpu_ctrl_ext
// Honours MCPU_EXC_EN (exception build uses a watchdog limit of 4).
module tb_mcpu_ctrl_ext;
`ifdef MCPU_EXC_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 200;
`endif

  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;
  logic [31:0] inst_in = 32'h0;
  logic PCWrite, PCWriteCond, Branch, mem_w, CPU_MIO, IRWrite, IorD, RegWrite;
  logic [1:0] PCSource, ALUSrc_A, ALUSrc_B, DatatoReg, RegDst, cause;
  logic [3:0] ALU_Control;
  logic [4:0] state_out;
  logic EPCWrite, CauseWrite;
  int checks = 0, errors = 0;

  mcpu_ctrl_ext #(.TMO_W(8), .TMO_MAX(8'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .inst_in(inst_in), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .mem_w(mem_w), .CPU_MIO(CPU_MIO), .IRWrite(IRWrite), .IorD(IorD), .RegWrite(RegWrite),
    .PCSource(PCSource), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .DatatoReg(DatatoReg),
    .RegDst(RegDst), .ALU_Control(ALU_Control), .state_out(state_out),
    .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef enum int {
    I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT, I_SLTU, I_SLL, I_SRL, I_SRA,
    I_JR, I_JALR, I_ADDI, I_ADDIU, I_ANDI, I_ORI, I_XORI, I_SLTI, I_SLTIU,
    I_LUI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_BAD
  } kind_t;

  typedef struct packed {
    logic pcw, pcwc, br, memw, mio, irw, iord, rw;
    logic [1:0] pcs, asa, asb, dtr, rdst;
    logic [3:0] alu;
    logic epc, cw;
    logic [1:0] cause;
  } ctl_t;

  function automatic kind_t classify(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20: return I_ADD;  6'h21: return I_ADDU; 6'h22: return I_SUB;  6'h23: return I_SUBU;
        6'h24: return I_AND;  6'h25: return I_OR;   6'h26: return I_XOR;  6'h27: return I_NOR;
        6'h2A: return I_SLT;  6'h2B: return I_SLTU; 6'h00: return I_SLL;  6'h02: return I_SRL;
        6'h03: return I_SRA;  6'h08: return I_JR;   6'h09: return I_JALR;
        default: return I_BAD;
      endcase
    end
    case (i[31:26])
      6'h08: return I_ADDI; 6'h09: return I_ADDIU; 6'h0C: return I_ANDI; 6'h0D: return I_ORI;
      6'h0E: return I_XORI; 6'h0A: return I_SLTI;  6'h0B: return I_SLTIU; 6'h0F: return I_LUI;
      6'h23: return I_LW;   6'h2B: return I_SW;    6'h04: return I_BEQ;  6'h05: return I_BNE;
      6'h02: return I_J;    6'h03: return I_JAL;
      default: return I_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input kind_t k);
    case (k)
      I_ADDU, I_ADDIU: return 4'b0110;
      I_SUB:           return 4'b0101;
      I_SUBU:          return 4'b0111;
      I_AND, I_ANDI:   return 4'b0000;
      I_OR, I_ORI:     return 4'b0001;
      I_XOR, I_XORI:   return 4'b0010;
      I_NOR:           return 4'b0011;
      I_SLT, I_SLTI:   return 4'b1011;
      I_SLTU, I_SLTIU: return 4'b1100;
      I_SLL:           return 4'b1000;
      I_SRL:           return 4'b1001;
      I_SRA:           return 4'b1010;
      default:         return 4'b0100;
    endcase
  endfunction

  function automatic int id_target(input kind_t k);
    if (int'(k) <= int'(I_SRA)) return 2;
    if (int'(k) >= int'(I_ADDI) && int'(k) <= int'(I_SLTIU)) return 4;
    case (k)
      I_JR: return 9;  I_JALR: return 10; I_LUI: return 16; I_LW, I_SW: return 3;
      I_BEQ: return 5; I_BNE: return 6;   I_J: return 7;    I_JAL: return 8;
`ifdef MCPU_EXC_EN
      default: return 17;
`else
      default: return 31;
`endif
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int st, input kind_t k, input logic rdy,
                                      input logic z, input logic [1:0] c);
    ctl_t e;
    e = '0;
    case (st)
      0: begin e.mio = 1; e.asb = 2'b01; e.alu = 4'b0100; e.irw = rdy; e.pcw = rdy; end
      2: begin e.alu = alu_of(k); e.asa = (k == I_SLL || k == I_SRL || k == I_SRA) ? 2'b10 : 2'b01; end
      3: begin e.alu = 4'b0100; e.asa = 2'b01; end
      4: begin e.alu = alu_of(k); e.asa = 2'b01; end
      5, 6: begin
        e.pcwc = 1; e.pcs = 2'b01; e.alu = 4'b0101; e.asa = 2'b01; e.br = (st == 5) ? z : ~z;
      end
      7: begin e.pcw = 1; e.pcs = 2'b10; end
      8: begin e.pcw = 1; e.pcs = 2'b10; e.rw = 1; e.dtr = 2'b11; e.rdst = 2'b10; end
      9: begin e.pcw = 1; e.pcs = 2'b11; end
      10: begin e.pcw = 1; e.pcs = 2'b11; e.rw = 1; e.dtr = 2'b11; e.rdst = 2'b01; end
      11: begin e.mio = 1; e.iord = 1; end
      12: begin e.mio = 1; e.iord = 1; e.memw = rdy; end
      13: begin e.rw = 1; e.rdst = 2'b01; end
      14: e.rw = 1;
      15: begin e.rw = 1; e.dtr = 2'b01; end
      16: begin e.rw = 1; e.dtr = 2'b10; end
      17: begin e.epc = 1; e.cw = 1; e.pcw = 1; e.pcs = 2'b11; e.cause = c; end
      default: ;
    endcase
    return e;
  endfunction

  int exp_state = 0, exp_next = 0, stall_run = 0;
  logic [1:0] exp_cause = 2'b00, cause_next = 2'b00;

  always @(negedge clk) begin
    ctl_t e, a;
    kind_t k;
    exp_state = exp_next;
    exp_cause = cause_next;
    if (!rst_n) begin exp_state = 0; exp_cause = 2'b00; stall_run = 0; end
    k = classify(inst_in);
    e = expect_ctl(exp_state, k, MIO_ready, zero, exp_cause);
    a.pcw = PCWrite; a.pcwc = PCWriteCond; a.br = Branch; a.memw = mem_w; a.mio = CPU_MIO;
    a.irw = IRWrite; a.iord = IorD; a.rw = RegWrite; a.pcs = PCSource; a.asa = ALUSrc_A;
    a.asb = ALUSrc_B; a.dtr = DatatoReg; a.rdst = RegDst; a.alu = ALU_Control;
    a.epc = EPCWrite; a.cw = CauseWrite; a.cause = cause;
    checks++;
    if (state_out !== 5'(exp_state)) begin
      errors++;
      $display("FAIL model_state t=%0t got=%0d exp=%0d", $time, state_out, exp_state);
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model_ctl t=%0t state=%0d got=%h exp=%h", $time, exp_state, a, e);
    end
    cause_next = 2'b00;
    if (!rst_n) begin
      exp_next = 0;
    end else begin
      case (exp_state)
        0:  exp_next = MIO_ready ? 1 : 0;
        1:  exp_next = id_target(k);
        2:  exp_next = 13;
        3:  exp_next = (k == I_LW) ? 11 : 12;
        4:  exp_next = 14;
        11: exp_next = MIO_ready ? 15 : 11;
        12: exp_next = MIO_ready ? 0 : 12;
        default: exp_next = 0;
      endcase
`ifdef MCPU_EXC_EN
      if (exp_state == 1 && k == I_BAD) cause_next = 2'b01;
      if (overflow && ((exp_state == 2 && (k == I_ADD || k == I_SUB)) ||
                       (exp_state == 4 && k == I_ADDI))) begin
        exp_next = 17; cause_next = 2'b11;
      end
      if ((exp_state == 0 || exp_state == 11 || exp_state == 12) && !MIO_ready) begin
        stall_run++;
        if (stall_run == TMO) begin exp_next = 17; cause_next = 2'b10; stall_run = 0; end
      end else begin
        stall_run = 0;
      end
`endif
    end
  end

  function automatic logic [5:0] rfun(input int s);
    case (s)
      0: return 6'h20; 1: return 6'h21; 2: return 6'h22; 3: return 6'h23; 4: return 6'h24;
      5: return 6'h25; 6: return 6'h26; 7: return 6'h27; 8: return 6'h2A; 9: return 6'h2B;
      10: return 6'h00; 11: return 6'h02; 12: return 6'h03; 13: return 6'h08; default: return 6'h09;
    endcase
  endfunction

  function automatic logic [5:0] iop(input int s);
    case (s)
      0: return 6'h08; 1: return 6'h09; 2: return 6'h0C; 3: return 6'h0D; 4: return 6'h0E;
      5: return 6'h0A; 6: return 6'h0B; 7: return 6'h0F; 8: return 6'h23; 9: return 6'h2B;
      10: return 6'h04; 11: return 6'h05; 12: return 6'h02; default: return 6'h03;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int sel;
    r = $urandom();
    sel = $urandom_range(0, 31);
    if (sel <= 14) begin r[31:26] = 6'h00; r[5:0] = rfun(sel); end
    else if (sel <= 28) r[31:26] = iop(sel - 15);
    else if (sel == 29) r[31:26] = 6'h3F;
    else if (sel == 30) r[31:26] = 6'h00;
    return r;
  endfunction

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic rdy, input logic [31:0] ins, input logic z, input logic ov);
    MIO_ready = rdy; inst_in = ins; zero = z; overflow = ov;
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD = 32'h012A4020, LW = 32'h8D280004, SW = 32'hAD280004;
  localparam logic [31:0] BNE = 32'h15280003, BAD = 32'hFC000000;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    set_in(1'b1, ADD, 1'b0, 1'b0);
    lit("add_if", 32'(state_out), 0);
    next_cyc(); lit("add_id", 32'(state_out), 1);
    next_cyc(); lit("add_ex", 32'(state_out), 2); lit("add_alu", 32'(ALU_Control), 4'b0100);
    lit("add_ex_rw", 32'(RegWrite), 0);
    next_cyc(); lit("add_wb", 32'(state_out), 13); lit("add_wb_rw", 32'(RegWrite), 1);
    next_cyc(); lit("add_done", 32'(state_out), 0);

    set_in(1'b1, LW, 1'b0, 1'b0);
    next_cyc(); next_cyc(); lit("lw_exmem", 32'(state_out), 3);
    next_cyc(); set_in(1'b0, LW, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      lit("lw_stall", 32'(state_out), 11); lit("lw_stall_rw", 32'(RegWrite), 0);
      next_cyc();
    end
    set_in(1'b1, LW, 1'b0, 1'b0);
    lit("lw_ready", 32'(state_out), 11);
    next_cyc(); lit("lw_wb", 32'(state_out), 15); lit("lw_wb_rw", 32'(RegWrite), 1);
    next_cyc(); lit("lw_done", 32'(state_out), 0);

    for (int zv = 0; zv < 2; zv++) begin
      set_in(1'b1, BNE, zv[0], 1'b0);
      next_cyc(); next_cyc();
      lit("bne_state", 32'(state_out), 6); lit("bne_pcwc", 32'(PCWriteCond), 1);
      lit("bne_branch", 32'(Branch), (zv == 0) ? 1 : 0); lit("bne_pcsrc", 32'(PCSource), 1);
      next_cyc(); lit("bne_done", 32'(state_out), 0);
    end

    set_in(1'b1, BAD, 1'b0, 1'b0);
    next_cyc(); lit("ill_id", 32'(state_out), 1);
    next_cyc();
`ifdef MCPU_EXC_EN
    lit("ill_exc", 32'(state_out), 17); lit("ill_epc", 32'(EPCWrite), 1);
    lit("ill_cause", 32'(cause), 2'b01);
`else
    lit("ill_err", 32'(state_out), 31); lit("ill_err_pcw", 32'(PCWrite), 0);
    lit("ill_cause0", 32'(cause), 0);
`endif
    next_cyc(); lit("ill_done", 32'(state_out), 0);

`ifdef MCPU_EXC_EN
    set_in(1'b0, ADD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      lit("tmo_stall", 32'(state_out), 0);
      next_cyc();
    end
    lit("tmo_exc", 32'(state_out), 17); lit("tmo_cause", 32'(cause), 2'b10);
    set_in(1'b1, ADD, 1'b0, 1'b0);
    next_cyc(); lit("tmo_done", 32'(state_out), 0);
`endif

    set_in(1'b1, SW, 1'b0, 1'b0);
    next_cyc(); next_cyc(); next_cyc();
    set_in(1'b0, SW, 1'b0, 1'b0);
    lit("rst_memwd", 32'(state_out), 12); lit("rst_memwd_w", 32'(mem_w), 0);
    #1 rst_n = 1'b0;
    #1 lit("rst_async", 32'(state_out), 0); lit("rst_memw", 32'(mem_w), 0);
    next_cyc();
    rst_n = 1'b1;
    set_in(1'b1, ADD, 1'b0, 1'b0);
    lit("rst_if", 32'(state_out), 0);
    next_cyc(); lit("rst_fetch", 32'(state_out), 1);

    for (int n = 0; n < 4000; n++) begin
      next_cyc();
      if (exp_next == 0) inst_in = rand_inst();
      MIO_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      overflow = ($urandom_range(0, 5) == 0);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
    end
    next_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
